alu_seq: RTL and testbench

Parametrised successor to the 8-bit adder ALU of the Eater-style computer. It adds an opcode-selected operation set, a registered result with a tri-state drive onto the shared bus, four latched flags (C, Z, N, V), and an iterative multi-cycle multiply with a busy handshake. It sits between the A/B registers and the system bus. The control sequencer drives op/start/fi/out.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_mul_iter.sv | 61 ++++++
 rtl/alu_seq.sv | 160 ++++++++++++++++
 tb/tb_alu_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU: opcodes, control states
// and bit positions inside the packed flag register.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_ADC = 4'd2,
        OP_SBC = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_SHL = 4'd7,
        OP_SHR = 4'd8,
        OP_MUL = 4'd9
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } fsm_t;

    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 2;
    localparam int FLG_V = 3;

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier: one partial product per clock after load,
// done is high during the final step with the complete product on product.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_next;

    always_comb begin
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = CW'(WIDTH);
        end else if (cnt_q != '0) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    // The last step's sum is presented combinationally so the caller can
    // latch the full product on the same edge that finishes the count.
    assign done    = (cnt_q == CW'(1));
    assign product = acc_next;

endmodule

// File: rtl/alu_seq.sv
// Opcode-driven ALU with registered result, latched C/Z/N/V flags, tri-state
// bus drive and an optional iterative multiply guarded by busy.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             start,
    input  logic             fi,
    input  logic             out,
    output logic [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             busy,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    fsm_t             state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] h_q, h_d;
    logic [3:0]       flags_q, flags_d;
    logic             fi_mul_q, fi_mul_d;

    logic               mul_load;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH-1:0] b_op;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic             v_arith;
    logic [WIDTH-1:0] res;
    logic             c_new;
    logic             v_new;
    logic             upd;

    always_comb begin
        b_op = ((op_t'(op) == OP_SUB) || (op_t'(op) == OP_SBC)) ? ~b : b;
        case (op_t'(op))
            OP_SUB:          cin = 1'b1;
            OP_ADC, OP_SBC:  cin = flags_q[FLG_C];
            default:         cin = 1'b0;
        endcase
        sum     = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
        v_arith = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

        res   = r_q;
        c_new = 1'b0;
        v_new = 1'b0;
        upd   = 1'b0;
        case (op_t'(op))
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                res   = sum[WIDTH-1:0];
                c_new = sum[WIDTH];
                v_new = v_arith;
                upd   = 1'b1;
            end
            OP_AND: begin res = a & b; upd = 1'b1; end
            OP_OR:  begin res = a | b; upd = 1'b1; end
            OP_XOR: begin res = a ^ b; upd = 1'b1; end
            OP_SHL: begin res = {a[WIDTH-2:0], 1'b0}; c_new = a[WIDTH-1]; upd = 1'b1; end
            OP_SHR: begin res = {1'b0, a[WIDTH-1:1]}; c_new = a[0];       upd = 1'b1; end
            default: ;
        endcase

        state_d  = state_q;
        r_d      = r_q;
        h_d      = h_q;
        flags_d  = flags_q;
        fi_mul_d = fi_mul_q;
        mul_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (upd) begin
                        r_d = res;
                        if (fi) begin
                            flags_d[FLG_C] = c_new;
                            flags_d[FLG_Z] = (res == '0);
                            flags_d[FLG_N] = res[WIDTH-1];
                            flags_d[FLG_V] = v_new;
                        end
                    end else if (MUL_EN && (op_t'(op) == OP_MUL)) begin
                        mul_load = 1'b1;
                        fi_mul_d = fi;
                        state_d  = ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                // New starts are dropped here; only completion moves us on.
                if (mul_done) begin
                    r_d     = mul_prod[WIDTH-1:0];
                    h_d     = mul_prod[2*WIDTH-1:WIDTH];
                    state_d = ST_IDLE;
                    if (fi_mul_q) begin
                        flags_d[FLG_C] = |mul_prod[2*WIDTH-1:WIDTH];
                        flags_d[FLG_Z] = (mul_prod == '0);
                        flags_d[FLG_N] = mul_prod[2*WIDTH-1];
                        flags_d[FLG_V] = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= ST_IDLE;
            r_q      <= '0;
            h_q      <= '0;
            flags_q  <= '0;
            fi_mul_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            h_q      <= h_d;
            flags_q  <= flags_d;
            fi_mul_q <= fi_mul_d;
        end
    end

    generate
        if (MUL_EN) begin : g_mul
            alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .clr_n   (clr_n),
                .load    (mul_load),
                .a       (a),
                .b       (b),
                .done    (mul_done),
                .product (mul_prod)
            );
        end else begin : g_no_mul
            assign mul_done = 1'b0;
            assign mul_prod = '0;
        end
    endgenerate

    assign bus       = out ? r_q : {WIDTH{1'bz}};
    assign result    = r_q;
    assign result_hi = h_q;
    assign busy      = (state_q == ST_MUL);
    assign carry     = flags_q[FLG_C];
    assign zero      = flags_q[FLG_Z];
    assign negative  = flags_q[FLG_N];
    assign overflow  = flags_q[FLG_V];

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: arithmetic/logic ops, flag latching, multiply
// latency and start lockout, mid-multiply reset, bus drive and NOP opcodes.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       clr_n;
    logic [7:0] a, b;
    logic [3:0] op;
    logic       start, fi, out;
    wire  [7:0] bus;
    logic [7:0] result, result_hi;
    logic       busy, carry, zero, negative, overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int edges;

    alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .a         (a),
        .b         (b),
        .op        (op),
        .start     (start),
        .fi        (fi),
        .out       (out),
        .bus       (bus),
        .result    (result),
        .result_hi (result_hi),
        .busy      (busy),
        .carry     (carry),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Flags packed as {C,Z,N,V}.
    function automatic logic [3:0] flags();
        return {carry, zero, negative, overflow};
    endfunction

    task automatic issue(input logic [3:0] o, input logic [7:0] aa, input logic [7:0] bb,
                         input logic f);
        @(negedge clk);
        op = o; a = aa; b = bb; fi = f; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        while (busy && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr_n = 1'b0; start = 1'b0; fi = 1'b0; out = 1'b0;
        op = 4'd0; a = 8'h00; b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_r",     result, 8'h00);
        check("rst_h",     result_hi, 8'h00);
        check("rst_flags", flags(), 4'b0000);
        check("rst_busy",  busy, 1'b0);
        @(negedge clk);
        clr_n = 1'b1;

        issue(4'd0, 8'h7F, 8'h01, 1'b1);
        check("add_r",     result, 8'h80);
        check("add_flags", flags(), 4'b0011);
        check("add_busy",  busy, 1'b0);

        issue(4'd1, 8'h05, 8'h05, 1'b1);
        check("sub_eq_r",     result, 8'h00);
        check("sub_eq_flags", flags(), 4'b1100);

        issue(4'd4, 8'h01, 8'h01, 1'b1);
        check("and_clr_r",     result, 8'h01);
        check("and_clr_flags", flags(), 4'b0000);

        issue(4'd1, 8'h05, 8'h05, 1'b0);
        check("sub_nofi_r",     result, 8'h00);
        check("sub_nofi_flags", flags(), 4'b0000);

        issue(4'd1, 8'h05, 8'h06, 1'b1);
        check("sub_brw_r",     result, 8'hFF);
        check("sub_brw_flags", flags(), 4'b0010);

        issue(4'd3, 8'h10, 8'h01, 1'b1);
        check("sbc_r",     result, 8'h0E);
        check("sbc_flags", flags(), 4'b1000);

        issue(4'd2, 8'hFF, 8'h00, 1'b1);
        check("adc_r",     result, 8'h00);
        check("adc_flags", flags(), 4'b1100);

        issue(4'd4, 8'hF0, 8'h3C, 1'b1);
        check("and_r",     result, 8'h30);
        check("and_flags", flags(), 4'b0000);

        issue(4'd9, 8'h10, 8'h10, 1'b1);
        edges = 0;
        check("mul_busy0", busy, 1'b1);
        check("mul_r_old", result, 8'h30);
        repeat (2) begin
            @(posedge clk);
            #1;
            edges++;
        end
        issue(4'd0, 8'h01, 8'h02, 1'b1);
        edges++;
        check("mul_lock_r",    result, 8'h30);
        check("mul_lock_busy", busy, 1'b1);
        wait_idle();
        check("mul_latency", 16'(edges), 16'd8);
        check("mul_r",       result, 8'h00);
        check("mul_h",       result_hi, 8'h01);
        check("mul_flags",   flags(), 4'b1000);

        issue(4'd9, 8'hFF, 8'hFF, 1'b1);
        edges = 0;
        @(negedge clk);
        a = 8'h00; b = 8'h00;
        wait_idle();
        check("mulff_r",     result, 8'h01);
        check("mulff_h",     result_hi, 8'hFE);
        check("mulff_flags", flags(), 4'b1010);

        issue(4'd9, 8'h03, 8'h05, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        clr_n = 1'b0;
        #1;
        check("rstmul_busy",  busy, 1'b0);
        check("rstmul_r",     result, 8'h00);
        check("rstmul_h",     result_hi, 8'h00);
        check("rstmul_flags", flags(), 4'b0000);
        #2;
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        check("rstmul_idle", busy, 1'b0);
        check("rstmul_r2",   result, 8'h00);
        issue(4'd0, 8'h01, 8'h02, 1'b1);
        check("post_rst_add", result, 8'h03);

        issue(4'd0, 8'h12, 8'h34, 1'b0);
        check("add46_r", result, 8'h46);
        out = 1'b1;
        #1;
        check("bus_on", bus, 8'h46);
        out = 1'b0;
        #1;
        check("bus_off", (bus !== 8'h46), 1'b1);

        issue(4'd7, 8'h81, 8'h00, 1'b1);
        check("shl_r",     result, 8'h02);
        check("shl_flags", flags(), 4'b1000);

        issue(4'd8, 8'h81, 8'h00, 1'b1);
        check("shr_r",     result, 8'h40);
        check("shr_flags", flags(), 4'b1000);

        issue(4'd12, 8'hFF, 8'hFF, 1'b1);
        check("nop_r",     result, 8'h40);
        check("nop_h",     result_hi, 8'h00);
        check("nop_flags", flags(), 4'b1000);
        check("nop_busy",  busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
